apb_master_ctrl: RTL and testbench



---
 rtl/apb_pkg.sv | 31 +++
 rtl/apb_master_ctrl_if.sv | 34 +++
 rtl/apb_addr_decode.sv | 25 ++
 rtl/apb_master_ctrl.sv | 139 +++++++++++++
 tb/tb_apb_master_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator and its address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StErr
    } apb_state_e;

    // Peripheral regions, inclusive limits
    localparam logic [31:0] Region0Base  = 32'h8000_0000;
    localparam logic [31:0] Region0Limit = 32'h83FF_FFFF;
    localparam logic [31:0] Region1Base  = 32'h8400_0000;
    localparam logic [31:0] Region1Limit = 32'h87FF_FFFF;
    localparam logic [31:0] Region2Base  = 32'h8800_0000;
    localparam logic [31:0] Region2Limit = 32'h8BFF_FFFF;

    // One-hot peripheral selects
    localparam logic [2:0] PselNone = 3'b000;
    localparam logic [2:0] Psel0    = 3'b001;
    localparam logic [2:0] Psel1    = 3'b010;
    localparam logic [2:0] Psel2    = 3'b100;

    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus APB bus signals of the APB initiator.
interface apb_master_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [2:0]  Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;

    // Controller view
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, Prdata, Pready,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output Psel, Penable, Pwrite, Paddr, Pwdata
    );

    // Requester / APB-slave view
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, Prdata, Pready,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  Psel, Penable, Pwrite, Paddr, Pwdata
    );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational address decode: maps an address to a one-hot peripheral select or an error.
module apb_addr_decode
    import apb_pkg::*;
(
    input  logic [31:0] addr_i,
    output logic [2:0]  sel_o,
    output logic        err_o
);

    // Region lookup; anything outside the three windows is a decode error
    always_comb begin
        sel_o = PselNone;
        err_o = 1'b0;
        if (in_region(addr_i, Region0Base, Region0Limit)) begin
            sel_o = Psel0;
        end else if (in_region(addr_i, Region1Base, Region1Limit)) begin
            sel_o = Psel1;
        end else if (in_region(addr_i, Region2Base, Region2Limit)) begin
            sel_o = Psel2;
        end else begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: accepts one request at a time, runs SETUP/ACCESS with wait-state
// timeout, and returns a single-cycle registered response.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input logic               Hclk,
    input logic               Hresetn,
    apb_master_ctrl_if.master bus_io
);

    // Counter value on the last tolerated low-Pready ACCESS cycle
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    apb_state_e       state_q, state_d;
    logic [2:0]       psel_q, psel_d;
    logic             penable_q, penable_d;
    logic             pwrite_q, pwrite_d;
    logic [31:0]      paddr_q, paddr_d;
    logic [31:0]      pwdata_q, pwdata_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0] dec_sel;
    logic       dec_err;

    apb_addr_decode u_addr_decode (
        .addr_i (bus_io.req_addr),
        .sel_o  (dec_sel),
        .err_o  (dec_err)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.req_valid) begin
                    if (dec_err) begin
                        state_d     = StErr;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = StSetup;
                        psel_d   = dec_sel;
                        penable_d = 1'b0;
                        pwrite_d = bus_io.req_write;
                        paddr_d  = bus_io.req_addr;
                        pwdata_d = bus_io.req_wdata;
                        cnt_d    = '0;
                    end
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                // Pready wins over the timeout when both land on the same cycle
                if (bus_io.Pready) begin
                    state_d     = StIdle;
                    psel_d      = PselNone;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (!pwrite_q) begin
                        rsp_rdata_d = bus_io.Prdata;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d     = StIdle;
                    psel_d      = PselNone;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer silently
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= StIdle;
            psel_q      <= PselNone;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus_io.req_ready = (state_q == StIdle);
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_err   = rsp_err_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.Psel      = psel_q;
    assign bus_io.Penable   = penable_q;
    assign bus_io.Pwrite    = pwrite_q;
    assign bus_io.Paddr     = paddr_q;
    assign bus_io.Pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with TIMEOUT=4.
module tb_apb_master_ctrl;

    logic Hclk;
    logic Hresetn;
    int   n_cmp;
    int   n_err;

    apb_master_ctrl_if bus ();

    apb_master_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (5)
    ) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus_io  (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic [2:0] sel, input logic en,
                             input logic rv, input logic re);
        check_eq({tag, ".psel"},      32'(bus.Psel),      32'(sel));
        check_eq({tag, ".penable"},   32'(bus.Penable),   32'(en));
        check_eq({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
        check_eq({tag, ".rsp_err"},   32'(bus.rsp_err),   32'(re));
    endtask

    task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        Hresetn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.Prdata    = '0;
        bus.Pready    = 1'b1;

        // Reset state
        tick();
        tick();
        check_bus("rst", 3'b000, 1'b0, 1'b0, 1'b0);
        check_eq("rst.paddr", bus.Paddr, 32'h0);
        check_eq("rst.pwdata", bus.Pwdata, 32'h0);
        check_eq("rst.rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst.ready", 32'(bus.req_ready), 32'h1);
        Hresetn = 1'b1;
        tick();

        // Zero-wait write
        request(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
        bus.Pready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check_bus("wr.setup", 3'b001, 1'b0, 1'b0, 1'b0);
        check_eq("wr.setup.paddr", bus.Paddr, 32'h8000_0010);
        check_eq("wr.setup.ready", 32'(bus.req_ready), 32'h0);
        tick();
        check_bus("wr.access", 3'b001, 1'b1, 1'b0, 1'b0);
        check_eq("wr.access.pwdata", bus.Pwdata, 32'hDEAD_BEEF);
        check_eq("wr.access.pwrite", 32'(bus.Pwrite), 32'h1);
        tick();
        check_bus("wr.rsp", 3'b000, 1'b0, 1'b1, 1'b0);
        check_eq("wr.rsp.ready", 32'(bus.req_ready), 32'h1);
        check_eq("wr.rsp.pwdata_hold", bus.Pwdata, 32'hDEAD_BEEF);
        check_eq("wr.rsp.rdata", bus.rsp_rdata, 32'h0);
        tick();
        check_eq("wr.after.rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // Read with two wait states; Prdata garbage while not ready
        request(1'b0, 32'h8400_0004, 32'h0);
        bus.Pready = 1'b0;
        bus.Prdata = 32'hBAD0_BAD0;
        tick();
        bus.req_valid = 1'b0;
        check_bus("rd.setup", 3'b010, 1'b0, 1'b0, 1'b0);
        tick();
        check_bus("rd.wait1", 3'b010, 1'b1, 1'b0, 1'b0);
        tick();
        check_bus("rd.wait2", 3'b010, 1'b1, 1'b0, 1'b0);
        tick();
        check_bus("rd.last", 3'b010, 1'b1, 1'b0, 1'b0);
        bus.Pready = 1'b1;
        bus.Prdata = 32'h0000_0025;
        tick();
        check_bus("rd.rsp", 3'b000, 1'b0, 1'b1, 1'b0);
        check_eq("rd.rsp.rdata", bus.rsp_rdata, 32'h0000_0025);
        check_eq("rd.rsp.paddr_hold", bus.Paddr, 32'h8400_0004);

        // Decode error
        request(1'b0, 32'h9000_0000, 32'h0);
        bus.Prdata = 32'h1111_1111;
        tick();
        bus.req_valid = 1'b0;
        check_bus("derr.c1", 3'b000, 1'b0, 1'b1, 1'b1);
        check_eq("derr.c1.ready", 32'(bus.req_ready), 32'h0);
        tick();
        check_bus("derr.c2", 3'b000, 1'b0, 1'b0, 1'b0);
        check_eq("derr.c2.ready", 32'(bus.req_ready), 32'h1);
        check_eq("derr.rdata_hold", bus.rsp_rdata, 32'h0000_0025);

        // Timeout: four low-Pready ACCESS cycles then abort
        request(1'b0, 32'h8800_0000, 32'h0);
        bus.Pready = 1'b0;
        bus.Prdata = 32'h0000_0077;
        tick();
        bus.req_valid = 1'b0;
        check_bus("to.setup", 3'b100, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        check_bus("to.wait4", 3'b100, 1'b1, 1'b0, 1'b0);
        tick();
        check_bus("to.rsp", 3'b000, 1'b0, 1'b1, 1'b1);
        check_eq("to.rsp.rdata_hold", bus.rsp_rdata, 32'h0000_0025);
        check_eq("to.rsp.ready", 32'(bus.req_ready), 32'h1);
        // New request accepted in the response cycle
        request(1'b1, 32'h8000_0000, 32'h0000_5A5A);
        bus.Pready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check_bus("to.next.setup", 3'b001, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_bus("to.next.rsp", 3'b000, 1'b0, 1'b1, 1'b0);
        tick();

        // Back-to-back writes with req_valid held
        request(1'b1, 32'h8000_0020, 32'hAAAA_0001);
        tick();
        request(1'b1, 32'h8800_0040, 32'hBBBB_0002);
        check_bus("b2b.c1", 3'b001, 1'b0, 1'b0, 1'b0);
        check_eq("b2b.c1.paddr", bus.Paddr, 32'h8000_0020);
        tick();
        check_bus("b2b.c2", 3'b001, 1'b1, 1'b0, 1'b0);
        check_eq("b2b.c2.pwdata", bus.Pwdata, 32'hAAAA_0001);
        tick();
        check_bus("b2b.c3", 3'b000, 1'b0, 1'b1, 1'b0);
        check_eq("b2b.c3.ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 1'b0;
        check_bus("b2b.c4", 3'b100, 1'b0, 1'b0, 1'b0);
        check_eq("b2b.c4.paddr", bus.Paddr, 32'h8800_0040);
        tick();
        check_bus("b2b.c5", 3'b100, 1'b1, 1'b0, 1'b0);
        check_eq("b2b.c5.pwdata", bus.Pwdata, 32'hBBBB_0002);
        tick();
        check_bus("b2b.c6", 3'b000, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset asserted during ACCESS
        request(1'b0, 32'h8400_0000, 32'h0);
        bus.Pready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check_bus("mrst.access", 3'b010, 1'b1, 1'b0, 1'b0);
        Hresetn = 1'b0;
        #1;
        check_bus("mrst.async", 3'b000, 1'b0, 1'b0, 1'b0);
        check_eq("mrst.paddr", bus.Paddr, 32'h0);
        check_eq("mrst.pwdata", bus.Pwdata, 32'h0);
        check_eq("mrst.rdata", bus.rsp_rdata, 32'h0);
        check_eq("mrst.ready", 32'(bus.req_ready), 32'h1);
        bus.Pready = 1'b1;
        tick();
        check_eq("mrst.hold.rsp_valid", 32'(bus.rsp_valid), 32'h0);
        Hresetn = 1'b1;
        tick();
        check_eq("mrst.rel.rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check_eq("mrst.rel.ready", 32'(bus.req_ready), 32'h1);
        request(1'b0, 32'h8000_0100, 32'h0);
        bus.Prdata = 32'h0000_1234;
        tick();
        bus.req_valid = 1'b0;
        check_bus("mrst.post.setup", 3'b001, 1'b0, 1'b0, 1'b0);
        tick();
        check_bus("mrst.post.access", 3'b001, 1'b1, 1'b0, 1'b0);
        tick();
        check_bus("mrst.post.rsp", 3'b000, 1'b0, 1'b1, 1'b0);
        check_eq("mrst.post.rdata", bus.rsp_rdata, 32'h0000_1234);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
